// File: rtl/fft_peak_detect_if.sv
// Bin stream from the FFT core into the peak detector, plus the per-frame result bus.
interface fft_peak_detect_if #(
  parameter int W   = 16,
  parameter int LDN = 8
);
  logic                  fft_valid;
  logic signed [W-1:0]   fftr;
  logic signed [W-1:0]   ffti;
  logic                  peak_valid;
  logic [LDN-1:0]        peak_bin;
  logic [2*W-1:0]        peak_mag;
  logic [2*W+7:0]        energy;
  logic                  err_short;

  modport master (
    output fft_valid, fftr, ffti,
    input  peak_valid, peak_bin, peak_mag, energy, err_short
  );

  modport slave (
    input  fft_valid, fftr, ffti,
    output peak_valid, peak_bin, peak_mag, energy, err_short
  );
endinterface

// File: rtl/fft_peak_detect.sv
// Per-frame |X[k]|^2 peak search and energy sum over an N-bin FFT output stream.
// Two-stage squaring pipeline; result pulses in the 4th cycle after the last bin is sampled.
module fft_peak_detect #(
  parameter int N       = 256,
  parameter int LDN     = 8,
  parameter int W       = 16,
  parameter int SKIP_DC = 1,
  parameter int HALF    = 1
) (
  input  logic             clk,
  input  logic             reset,
  fft_peak_detect_if.slave bus,
  output logic             busy,
  output logic [LDN:0]     bin_cnt_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    FLUSH    = 3'd2,
    REPORT   = 3'd3,
    WAIT_LOW = 3'd4
  } state_t;

  localparam logic [LDN-1:0] FIRST_BIN = (SKIP_DC != 0) ? LDN'(1) : LDN'(0);
  localparam logic [LDN:0]   LAST_BIN  = (LDN+1)'(N - 1);

  state_t               state_q, state_d;
  logic [LDN:0]         bin_cnt_q, bin_cnt_d;
  logic                 flush_q, flush_d;
  logic                 sample, frame_start, short_frame;
  logic [LDN-1:0]       idx_in;
  logic                 inc_in;

  logic signed [2*W-1:0] re_ext, im_ext, re_sq, im_sq;

  logic                 s1_vld_q, s1_inc_q;
  logic [LDN-1:0]       s1_idx_q;
  logic [2*W-1:0]       s1_re2_q, s1_im2_q;
  logic [2*W-1:0]       mag;

  logic [2*W-1:0]       run_max_q;
  logic [LDN-1:0]       run_idx_q;
  logic [2*W+7:0]       run_energy_q;

  logic                 peak_valid_q, err_short_q;
  logic [LDN-1:0]       peak_bin_q;
  logic [2*W-1:0]       peak_mag_q;
  logic [2*W+7:0]       energy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bin_cnt_q <= '0;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_cnt_q <= bin_cnt_d;
      flush_q   <= flush_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bin_cnt_d   = bin_cnt_q;
    flush_d     = flush_q;
    sample      = 1'b0;
    frame_start = 1'b0;
    short_frame = 1'b0;
    idx_in      = bin_cnt_q[LDN-1:0];
    unique case (state_q)
      IDLE: begin
        if (bus.fft_valid) begin
          sample      = 1'b1;
          frame_start = 1'b1;
          idx_in      = '0;
          bin_cnt_d   = (LDN+1)'(1);
          state_d     = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.fft_valid) begin
          sample    = 1'b1;
          bin_cnt_d = bin_cnt_q + (LDN+1)'(1);
          if (bin_cnt_q == LAST_BIN) begin
            flush_d = 1'b0;
            state_d = FLUSH;
          end
        end else begin
          short_frame = 1'b1;
          bin_cnt_d   = '0;
          state_d     = IDLE;
        end
      end
      FLUSH: begin
        flush_d = ~flush_q;
        if (flush_q) state_d = REPORT;
      end
      REPORT: begin
        state_d = bus.fft_valid ? WAIT_LOW : IDLE;
      end
      WAIT_LOW: begin
        if (!bus.fft_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // DC and the mirrored upper half of a real-input spectrum are not searched.
  always_comb begin
    inc_in = 1'b1;
    if ((SKIP_DC != 0) && (idx_in == '0)) inc_in = 1'b0;
    if ((HALF != 0) && idx_in[LDN-1])     inc_in = 1'b0;
  end

  assign re_ext = {{W{bus.fftr[W-1]}}, bus.fftr};
  assign im_ext = {{W{bus.ffti[W-1]}}, bus.ffti};
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld_q <= 1'b0;
      s1_inc_q <= 1'b0;
      s1_idx_q <= '0;
      s1_re2_q <= '0;
      s1_im2_q <= '0;
    end else begin
      s1_vld_q <= sample;
      if (sample) begin
        s1_inc_q <= inc_in;
        s1_idx_q <= idx_in;
        s1_re2_q <= $unsigned(re_sq);
        s1_im2_q <= $unsigned(im_sq);
      end
    end
  end

  // Each square is at most 2^30, so the sum fits 2W bits unsigned.
  assign mag = s1_re2_q + s1_im2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_max_q    <= '0;
      run_idx_q    <= '0;
      run_energy_q <= '0;
    end else if (frame_start) begin
      run_max_q    <= '0;
      run_idx_q    <= FIRST_BIN;
      run_energy_q <= '0;
    end else if (s1_vld_q && s1_inc_q) begin
      run_energy_q <= run_energy_q + {8'd0, mag};
      if (mag > run_max_q) begin
        run_max_q <= mag;
        run_idx_q <= s1_idx_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_valid_q <= 1'b0;
      err_short_q  <= 1'b0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
      energy_q     <= '0;
    end else begin
      peak_valid_q <= (state_q == REPORT);
      err_short_q  <= short_frame;
      if (state_q == REPORT) begin
        peak_bin_q <= run_idx_q;
        peak_mag_q <= run_max_q;
        energy_q   <= run_energy_q;
      end
    end
  end

  assign bus.peak_valid = peak_valid_q;
  assign bus.peak_bin   = peak_bin_q;
  assign bus.peak_mag   = peak_mag_q;
  assign bus.energy     = energy_q;
  assign bus.err_short  = err_short_q;
  assign busy           = (state_q == COLLECT) || (state_q == FLUSH);
  assign bin_cnt_o      = bin_cnt_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Randomized and directed frames checked against a plain-arithmetic spectrum model.
module tb_fft_peak_detect;
  localparam int N = 256;
  localparam int LDN = 8;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy;
  logic [LDN:0] bin_cnt_o;

  fft_peak_detect_if #(.W(W), .LDN(LDN)) bus ();

  fft_peak_detect #(.N(N), .LDN(LDN), .W(W), .SKIP_DC(1), .HALF(1)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .bin_cnt_o(bin_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass = 0;

  int re_a[N];
  int im_a[N];

  int pv_cnt = 0;
  int pv_cyc = -1;
  int err_cnt = 0;
  int pv_bins[$];
  logic [LDN-1:0] cap_bin;
  logic [2*W-1:0] cap_mag;
  logic [2*W+7:0] cap_en;

  always @(negedge clk) begin
    if (bus.peak_valid === 1'b1) begin
      pv_cnt++;
      pv_cyc = cyc;
      pv_bins.push_back(int'(bus.peak_bin));
      cap_bin = bus.peak_bin;
      cap_mag = bus.peak_mag;
      cap_en  = bus.energy;
    end
    if (bus.err_short === 1'b1) err_cnt++;
  end

  function automatic int rnd_s16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Reference: searched bins are 1..N/2-1; strict max so the lowest index wins ties.
  task automatic model(output longint mag, output int idx, output longint en);
    longint m;
    mag = 0; idx = 1; en = 0;
    for (int k = 1; k < N / 2; k++) begin
      m = longint'(re_a[k]) * re_a[k] + longint'(im_a[k]) * im_a[k];
      en += m;
      if (m > mag) begin
        mag = m;
        idx = k;
      end
    end
  endtask

  task automatic clear_spec();
    for (int k = 0; k < N; k++) begin
      re_a[k] = 0;
      im_a[k] = 0;
    end
  endtask

  task automatic rand_spec(input int mode);
    for (int k = 0; k < N; k++) begin
      case (mode)
        0: begin re_a[k] = rnd_s16(); im_a[k] = rnd_s16(); end
        1: begin re_a[k] = int'($urandom_range(0, 4)) - 2; im_a[k] = int'($urandom_range(0, 4)) - 2; end
        default: begin
          re_a[k] = ($urandom_range(0, 7) == 0) ? rnd_s16() : 0;
          im_a[k] = ($urandom_range(0, 7) == 0) ? rnd_s16() : 0;
        end
      endcase
    end
  endtask

  task automatic run_frame(input int nhigh, input int ngap, output int edge_n1);
    edge_n1 = -1;
    for (int i = 0; i < nhigh; i++) begin
      @(posedge clk); #1;
      bus.fft_valid = 1'b1;
      if (i < N) begin
        bus.fftr = 16'(re_a[i]);
        bus.ffti = 16'(im_a[i]);
      end else begin
        bus.fftr = 16'($urandom);
        bus.ffti = 16'($urandom);
      end
      if (i == N - 1) edge_n1 = cyc + 1;
    end
    for (int i = 0; i < ngap; i++) begin
      @(posedge clk); #1;
      bus.fft_valid = 1'b0;
      bus.fftr = 16'($urandom);
      bus.ffti = 16'($urandom);
    end
  endtask

  task automatic reset_mon();
    pv_cnt = 0;
    err_cnt = 0;
    pv_bins.delete();
  endtask

  task automatic test_reset();
    longint em, ee;
    int ei, e1;
    bus.fft_valid = 1'b0; bus.fftr = '0; bus.ffti = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.peak_valid !== 1'b0 || bus.peak_bin !== '0 || bus.peak_mag !== '0 ||
        bus.energy !== '0 || bus.err_short !== 1'b0 || busy !== 1'b0 || bin_cnt_o !== '0)
      $display("FAIL reset_initial: pv=%b bin=%0d mag=%0d en=%0d err=%b busy=%b cnt=%0d, all required 0",
               bus.peak_valid, bus.peak_bin, bus.peak_mag, bus.energy, bus.err_short, busy, bin_cnt_o);
    else n_pass++;
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);
    rand_spec(0);
    model(em, ei, ee);
    reset_mon();
    run_frame(N + 2, 1, e1);
    repeat (8) @(posedge clk);
    n_checks++;
    if (pv_cnt !== 1 || cap_bin !== 8'(ei) || cap_mag !== 32'(em) || cap_en !== 40'(ee))
      $display("FAIL reset_preframe: pulses=%0d bin=%0d mag=%0d en=%0d, required 1 %0d %0d %0d",
               pv_cnt, cap_bin, cap_mag, cap_en, ei, em, ee);
    else n_pass++;
    // Interrupt a frame partway through collection.
    rand_spec(0);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      bus.fft_valid = 1'b1;
      bus.fftr = 16'(re_a[i]);
      bus.ffti = 16'(im_a[i]);
    end
    @(posedge clk); #2;
    n_checks++;
    if (busy !== 1'b1)
      $display("FAIL reset_busy_before: busy=%b, required 1", busy);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.peak_valid !== 1'b0 || bus.peak_bin !== '0 || bus.peak_mag !== '0 ||
        bus.energy !== '0 || bus.err_short !== 1'b0 || busy !== 1'b0 || bin_cnt_o !== '0)
      $display("FAIL reset_async: pv=%b bin=%0d mag=%0d en=%0d err=%b busy=%b cnt=%0d, all required 0",
               bus.peak_valid, bus.peak_bin, bus.peak_mag, bus.energy, bus.err_short, busy, bin_cnt_o);
    else n_pass++;
    bus.fft_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);
    rand_spec(2);
    model(em, ei, ee);
    reset_mon();
    run_frame(N + 2, 1, e1);
    repeat (8) @(posedge clk);
    n_checks++;
    if (pv_cnt !== 1 || cap_bin !== 8'(ei) || cap_mag !== 32'(em) || cap_en !== 40'(ee) || err_cnt !== 0)
      $display("FAIL reset_postframe: pulses=%0d bin=%0d mag=%0d en=%0d errs=%0d, required 1 %0d %0d %0d 0",
               pv_cnt, cap_bin, cap_mag, cap_en, err_cnt, ei, em, ee);
    else n_pass++;
  endtask

  task automatic test_single_tone();
    int e1;
    clear_spec();
    re_a[37] = 1000; im_a[37] = -500;
    reset_mon();
    run_frame(N + 2, 1, e1);
    repeat (8) @(posedge clk);
    n_checks++;
    if (pv_cnt !== 1)
      $display("FAIL tone_pulses: got %0d pulses, required 1", pv_cnt);
    else n_pass++;
    n_checks++;
    if (pv_cyc !== e1 + 3)
      $display("FAIL tone_latency: pulse at cycle %0d, required %0d", pv_cyc, e1 + 3);
    else n_pass++;
    n_checks++;
    if (cap_bin !== 8'd37 || cap_mag !== 32'd1250000 || cap_en !== 40'd1250000)
      $display("FAIL tone_values: bin=%0d mag=%0d en=%0d, required 37 1250000 1250000",
               cap_bin, cap_mag, cap_en);
    else n_pass++;
    n_checks++;
    if (bus.peak_bin !== 8'd37 || bus.peak_mag !== 32'd1250000)
      $display("FAIL tone_hold: bin=%0d mag=%0d after pulse, required 37 1250000", bus.peak_bin, bus.peak_mag);
    else n_pass++;
  endtask

  task automatic test_exclusion();
    int e1;
    clear_spec();
    re_a[0] = 30000;
    re_a[200] = 20000;
    re_a[5] = 100; im_a[5] = 100;
    reset_mon();
    run_frame(N + 2, 1, e1);
    repeat (8) @(posedge clk);
    n_checks++;
    if (pv_cnt !== 1 || cap_bin !== 8'd5 || cap_mag !== 32'd20000 || cap_en !== 40'd20000)
      $display("FAIL exclusion: pulses=%0d bin=%0d mag=%0d en=%0d, required 1 5 20000 20000",
               pv_cnt, cap_bin, cap_mag, cap_en);
    else n_pass++;
  endtask

  task automatic test_tie_extreme();
    int e1;
    clear_spec();
    re_a[10] = -32768; im_a[10] = -32768;
    re_a[20] = -32768; im_a[20] = -32768;
    reset_mon();
    run_frame(N + 2, 1, e1);
    repeat (8) @(posedge clk);
    n_checks++;
    if (pv_cnt !== 1 || cap_bin !== 8'd10 || cap_mag !== 32'h8000_0000 || cap_en !== 40'h01_0000_0000)
      $display("FAIL tie_extreme: pulses=%0d bin=%0d mag=%h en=%h, required 1 10 80000000 0100000000",
               pv_cnt, cap_bin, cap_mag, cap_en);
    else n_pass++;
  endtask

  task automatic test_all_zero();
    int e1;
    clear_spec();
    reset_mon();
    run_frame(N + 2, 1, e1);
    repeat (8) @(posedge clk);
    n_checks++;
    if (pv_cnt !== 1 || cap_bin !== 8'd1 || cap_mag !== '0 || cap_en !== '0)
      $display("FAIL all_zero: pulses=%0d bin=%0d mag=%0d en=%0d, required 1 1 0 0",
               pv_cnt, cap_bin, cap_mag, cap_en);
    else n_pass++;
  endtask

  task automatic test_short_frame();
    logic [LDN-1:0] pb;
    logic [2*W-1:0] pm;
    logic [2*W+7:0] pe;
    longint em, ee;
    int ei, e1, errs_hi;
    pb = bus.peak_bin; pm = bus.peak_mag; pe = bus.energy;
    rand_spec(0);
    reset_mon();
    run_frame(100, 1, e1);
    repeat (8) @(posedge clk);
    errs_hi = err_cnt;
    n_checks++;
    if (errs_hi !== 1)
      $display("FAIL short_err_pulse: err_short high for %0d cycles, required 1", errs_hi);
    else n_pass++;
    n_checks++;
    if (pv_cnt !== 0 || bus.peak_bin !== pb || bus.peak_mag !== pm || bus.energy !== pe)
      $display("FAIL short_hold: pulses=%0d bin=%0d mag=%0d en=%0d, required 0 %0d %0d %0d",
               pv_cnt, bus.peak_bin, bus.peak_mag, bus.energy, pb, pm, pe);
    else n_pass++;
    rand_spec(0);
    model(em, ei, ee);
    reset_mon();
    run_frame(N + 2, 1, e1);
    repeat (8) @(posedge clk);
    n_checks++;
    if (pv_cnt !== 1 || cap_bin !== 8'(ei) || cap_mag !== 32'(em) || cap_en !== 40'(ee) || err_cnt !== 0)
      $display("FAIL short_recover: pulses=%0d bin=%0d mag=%0d en=%0d errs=%0d, required 1 %0d %0d %0d 0",
               pv_cnt, cap_bin, cap_mag, cap_en, err_cnt, ei, em, ee);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int e1, e2;
    clear_spec();
    re_a[3] = 5000; im_a[3] = 7000;
    reset_mon();
    run_frame(N + 2, 1, e1);
    clear_spec();
    re_a[99] = -4000; im_a[99] = 300;
    run_frame(N + 2, 1, e2);
    repeat (8) @(posedge clk);
    n_checks++;
    if (pv_bins.size() !== 2)
      $display("FAIL b2b_count: %0d pulses, required 2", pv_bins.size());
    else n_pass++;
    n_checks++;
    if (pv_bins.size() < 2 || pv_bins[0] !== 3 || pv_bins[1] !== 99)
      $display("FAIL b2b_bins: got %p, required '{3, 99}", pv_bins);
    else n_pass++;
    n_checks++;
    if (cap_mag !== 32'd16090000 || cap_en !== 40'd16090000 || pv_cyc !== e2 + 3)
      $display("FAIL b2b_second: mag=%0d en=%0d at cycle %0d, required 16090000 16090000 at %0d",
               cap_mag, cap_en, pv_cyc, e2 + 3);
    else n_pass++;
  endtask

  task automatic test_wait_low();
    longint em, ee;
    int ei, e1;
    rand_spec(0);
    model(em, ei, ee);
    reset_mon();
    run_frame(N + 40, 2, e1);
    repeat (8) @(posedge clk);
    n_checks++;
    if (pv_cnt !== 1 || err_cnt !== 0 || cap_bin !== 8'(ei) || cap_mag !== 32'(em) || cap_en !== 40'(ee))
      $display("FAIL wait_low: pulses=%0d errs=%0d bin=%0d mag=%0d en=%0d, required 1 0 %0d %0d %0d",
               pv_cnt, err_cnt, cap_bin, cap_mag, cap_en, ei, em, ee);
    else n_pass++;
  endtask

  task automatic test_random();
    longint em, ee;
    int ei, e1;
    for (int f = 0; f < 6; f++) begin
      rand_spec(f % 3);
      model(em, ei, ee);
      reset_mon();
      run_frame(N + int'($urandom_range(0, 2)), 1 + int'($urandom_range(0, 3)), e1);
      repeat (8) @(posedge clk);
      n_checks++;
      if (pv_cnt !== 1 || cap_bin !== 8'(ei) || cap_mag !== 32'(em) || cap_en !== 40'(ee) || pv_cyc !== e1 + 3)
        $display("FAIL random_frame%0d: pulses=%0d bin=%0d mag=%0d en=%0d cyc=%0d, required 1 %0d %0d %0d %0d",
                 f, pv_cnt, cap_bin, cap_mag, cap_en, pv_cyc, ei, em, ee, e1 + 3);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_tone();
    test_exclusion();
    test_tie_extreme();
    test_all_zero();
    test_short_frame();
    test_back_to_back();
    test_wait_low();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
